disp_cmd_decoder: RTL and testbench

DISP_CMD_DECODER -- requirements
Module: disp_cmd_decoder

---
 rtl/disp_cmd_decoder.sv | 203 ++++++++++++++++++++
 tb/tb_disp_cmd_decoder.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_cmd_decoder.sv
// Byte-stream command decoder for a 100x37 text buffer: characters, cursor moves, attribute and clear.
// Build option: define CMD_BACKSPACE_EN to make 0x08 step the cursor back and blank that cell.
module disp_cmd_decoder (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  cmd_data,
   input  logic        cmd_avail,
   output logic        cmd_ack,
   output logic [11:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_we,
   output logic        busy
);

   localparam logic [6:0]  LAST_COL  = 7'd99;
   localparam logic [5:0]  LAST_ROW  = 6'd36;
   localparam logic [11:0] LAST_CELL = 12'd3699;
   localparam logic [7:0]  ATTR_RST  = 8'h0F;
   localparam logic [7:0]  BLANK     = 8'h20;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARG_ROW,
      S_ARG_COL,
      S_ARG_ATTR,
      S_CLEAR
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  row_q, row_d;
   logic [6:0]  col_q, col_d;
   logic [7:0]  attr_q, attr_d;
   logic [7:0]  arg_row_q, arg_row_d;
   logic [11:0] clr_addr_q, clr_addr_d;
   logic        ack_q, ack_d;
   logic        we_q, we_d;
   logic        busy_q, busy_d;
   logic [11:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;

   logic [11:0] cur_addr;
   logic [5:0]  row_inc;

   assign cur_addr = 12'(row_q) * 12'd100 + 12'(col_q);
   assign row_inc  = (row_q == LAST_ROW) ? 6'd0 : row_q + 6'd1;

`ifdef CMD_BACKSPACE_EN
   logic [5:0]  bs_row;
   logic [6:0]  bs_col;
   logic [11:0] bs_addr;

   always_comb begin
      bs_row = row_q;
      bs_col = col_q;
      if (col_q != 7'd0) begin
         bs_col = col_q - 7'd1;
      end else if (row_q != 6'd0) begin
         bs_row = row_q - 6'd1;
         bs_col = LAST_COL;
      end
   end

   assign bs_addr = 12'(bs_row) * 12'd100 + 12'(bs_col);
`endif

   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      attr_d     = attr_q;
      arg_row_d  = arg_row_q;
      clr_addr_d = clr_addr_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = 1'b0;
      busy_d     = 1'b0;
      // ack_q marks the cycle whose cmd_data is consumed, so never two in a row
      ack_d      = (state_q != S_CLEAR) && cmd_avail && !ack_q;

      case (state_q)
         S_IDLE: begin
            if (ack_q) begin
               if (cmd_data >= 8'h20 && cmd_data <= 8'h7E) begin
                  we_d    = 1'b1;
                  addr_d  = cur_addr;
                  wdata_d = {attr_q, cmd_data};
                  if (col_q == LAST_COL) begin
                     col_d = 7'd0;
                     row_d = row_inc;
                  end else begin
                     col_d = col_q + 7'd1;
                  end
               end else begin
                  case (cmd_data)
                     8'h0A: begin
                        col_d = 7'd0;
                        row_d = row_inc;
                     end
                     8'h0D: col_d = 7'd0;
                     8'h01: state_d = S_ARG_ROW;
                     8'h02: state_d = S_ARG_ATTR;
                     8'h03: begin
                        // first fill write goes out with the ack edge; the rest come from S_CLEAR
                        we_d       = 1'b1;
                        busy_d     = 1'b1;
                        addr_d     = 12'd0;
                        wdata_d    = {attr_q, BLANK};
                        clr_addr_d = 12'd1;
                        state_d    = S_CLEAR;
                     end
`ifdef CMD_BACKSPACE_EN
                     8'h08: begin
                        row_d   = bs_row;
                        col_d   = bs_col;
                        we_d    = 1'b1;
                        addr_d  = bs_addr;
                        wdata_d = {attr_q, BLANK};
                     end
`else
                     8'h08: ;
`endif
                     default: ;
                  endcase
               end
            end
         end

         S_ARG_ROW: begin
            if (ack_q) begin
               arg_row_d = cmd_data;
               state_d   = S_ARG_COL;
            end
         end

         S_ARG_COL: begin
            if (ack_q) begin
               if (arg_row_q <= 8'(LAST_ROW) && cmd_data <= 8'(LAST_COL)) begin
                  row_d = arg_row_q[5:0];
                  col_d = cmd_data[6:0];
               end
               state_d = S_IDLE;
            end
         end

         S_ARG_ATTR: begin
            if (ack_q) begin
               attr_d  = cmd_data;
               state_d = S_IDLE;
            end
         end

         S_CLEAR: begin
            we_d       = 1'b1;
            busy_d     = 1'b1;
            addr_d     = clr_addr_q;
            wdata_d    = {attr_q, BLANK};
            clr_addr_d = clr_addr_q + 12'd1;
            if (clr_addr_q == LAST_CELL) begin
               row_d   = 6'd0;
               col_d   = 7'd0;
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         row_q      <= 6'd0;
         col_q      <= 7'd0;
         attr_q     <= ATTR_RST;
         arg_row_q  <= 8'd0;
         clr_addr_q <= 12'd0;
         ack_q      <= 1'b0;
         we_q       <= 1'b0;
         busy_q     <= 1'b0;
         addr_q     <= 12'd0;
         wdata_q    <= 16'd0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         attr_q     <= attr_d;
         arg_row_q  <= arg_row_d;
         clr_addr_q <= clr_addr_d;
         ack_q      <= ack_d;
         we_q       <= we_d;
         busy_q     <= busy_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
      end
   end

   assign cmd_ack   = ack_q;
   assign mem_we    = we_q;
   assign busy      = busy_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_disp_cmd_decoder.sv
// Directed bench for disp_cmd_decoder: characters, cursor commands, clear fill, reset aborts.
module tb_disp_cmd_decoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  cmd_data = 8'h00;
   logic        cmd_avail = 1'b0;
   logic        cmd_ack;
   logic [11:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_we;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   disp_cmd_decoder dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_data  (cmd_data),
      .cmd_avail (cmd_avail),
      .cmd_ack   (cmd_ack),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Present a byte and return on the falling edge inside its ack cycle.
   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk);
      cmd_data  = b;
      cmd_avail = 1'b1;
      @(negedge clk);
      while (cmd_ack !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (cmd_ack !== 1'b1) begin
         n_bad++;
         $display("FAIL ack_timeout: byte %h got no ack, cmd_ack=%b want 1", b, cmd_ack);
      end
      cmd_avail = 1'b0;
   endtask

   task automatic test_reset;
      rst       = 1'b1;
      cmd_avail = 1'b1;
      cmd_data  = 8'h41;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (cmd_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", cmd_ack); end
      n_cmp++;
      if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", mem_we); end
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++;
      if ({mem_addr, mem_wdata} !== 28'd0) begin
         n_bad++;
         $display("FAIL reset_bus: got addr=%0d wdata=%h want addr=0 wdata=0000", mem_addr, mem_wdata);
      end
      cmd_avail = 1'b0;
      rst       = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_char;
      send(8'h41);
      @(negedge clk);
      n_cmp++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'd0, 16'h0F41}) begin
         n_bad++;
         $display("FAIL char_first: got we=%b addr=%0d wdata=%h want we=1 addr=0 wdata=0f41", mem_we, mem_addr, mem_wdata);
      end
      @(negedge clk);
      n_cmp++;
      if (mem_we !== 1'b0) begin n_bad++; $display("FAIL char_one_cycle: got we=%b want 0", mem_we); end
      send(8'h42);
      @(negedge clk);
      n_cmp++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'd1, 16'h0F42}) begin
         n_bad++;
         $display("FAIL char_advance: got we=%b addr=%0d wdata=%h want we=1 addr=1 wdata=0f42", mem_we, mem_addr, mem_wdata);
      end
   endtask

   task automatic test_setpos_wrap;
      send(8'h01); send(8'h24); send(8'h63);
      send(8'h5A);
      @(negedge clk);
      n_cmp++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'd3699, 16'h0F5A}) begin
         n_bad++;
         $display("FAIL setpos_last: got we=%b addr=%0d wdata=%h want we=1 addr=3699 wdata=0f5a", mem_we, mem_addr, mem_wdata);
      end
      send(8'h43);
      @(negedge clk);
      n_cmp++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'd0, 16'h0F43}) begin
         n_bad++;
         $display("FAIL wrap_to_origin: got we=%b addr=%0d wdata=%h want we=1 addr=0 wdata=0f43", mem_we, mem_addr, mem_wdata);
      end
   endtask

   task automatic test_out_of_range;
      send(8'h01); send(8'h40); send(8'h05);
      send(8'h44);
      @(negedge clk);
      n_cmp++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'd1, 16'h0F44}) begin
         n_bad++;
         $display("FAIL row_oob: got we=%b addr=%0d wdata=%h want we=1 addr=1 wdata=0f44", mem_we, mem_addr, mem_wdata);
      end
      send(8'h01); send(8'h05); send(8'h64);
      send(8'h45);
      @(negedge clk);
      n_cmp++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'd2, 16'h0F45}) begin
         n_bad++;
         $display("FAIL col_oob: got we=%b addr=%0d wdata=%h want we=1 addr=2 wdata=0f45", mem_we, mem_addr, mem_wdata);
      end
   endtask

   task automatic test_newline;
      send(8'h0A);
      @(negedge clk);
      n_cmp++;
      if (mem_we !== 1'b0) begin n_bad++; $display("FAIL lf_nowrite: got we=%b want 0", mem_we); end
      send(8'h46);
      @(negedge clk);
      n_cmp++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'd100, 16'h0F46}) begin
         n_bad++;
         $display("FAIL lf_pos: got we=%b addr=%0d wdata=%h want we=1 addr=100 wdata=0f46", mem_we, mem_addr, mem_wdata);
      end
      send(8'h0D);
      send(8'h47);
      @(negedge clk);
      n_cmp++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'd100, 16'h0F47}) begin
         n_bad++;
         $display("FAIL cr_pos: got we=%b addr=%0d wdata=%h want we=1 addr=100 wdata=0f47", mem_we, mem_addr, mem_wdata);
      end
      send(8'h07);
      @(negedge clk);
      n_cmp++;
      if (mem_we !== 1'b0) begin n_bad++; $display("FAIL unknown_nowrite: got we=%b want 0", mem_we); end
      send(8'h7F);
      @(negedge clk);
      n_cmp++;
      if (mem_we !== 1'b0) begin n_bad++; $display("FAIL del_nowrite: got we=%b want 0", mem_we); end
      send(8'h7E);
      @(negedge clk);
      n_cmp++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'd101, 16'h0F7E}) begin
         n_bad++;
         $display("FAIL tilde_pos: got we=%b addr=%0d wdata=%h want we=1 addr=101 wdata=0f7e", mem_we, mem_addr, mem_wdata);
      end
   endtask

   task automatic test_backspace;
      logic [28:0] want;
      send(8'h01); send(8'h01); send(8'h00);
      send(8'h08);
      @(negedge clk);
      n_cmp++;
`ifdef CMD_BACKSPACE_EN
      want = {1'b1, 12'd99, 16'h0F20};
      if ({mem_we, mem_addr, mem_wdata} !== want) begin
         n_bad++;
         $display("FAIL bs_write: got we=%b addr=%0d wdata=%h want we=1 addr=99 wdata=0f20", mem_we, mem_addr, mem_wdata);
      end
`else
      want = {1'b1, 12'd100, 16'h0F49};
      if (mem_we !== 1'b0) begin n_bad++; $display("FAIL bs_ignored: got we=%b want 0", mem_we); end
`endif
`ifdef CMD_BACKSPACE_EN
      want = {1'b1, 12'd99, 16'h0F49};
`endif
      send(8'h49);
      @(negedge clk);
      n_cmp++;
      if ({mem_we, mem_addr, mem_wdata} !== want) begin
         n_bad++;
         $display("FAIL bs_after: got we=%b addr=%0d wdata=%h want we=1 addr=%0d wdata=%h", mem_we, mem_addr, mem_wdata, want[27:16], want[15:0]);
      end
      send(8'h01); send(8'h00); send(8'h00);
      send(8'h08);
      @(negedge clk);
      n_cmp++;
`ifdef CMD_BACKSPACE_EN
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'd0, 16'h0F20}) begin
         n_bad++;
         $display("FAIL bs_origin: got we=%b addr=%0d wdata=%h want we=1 addr=0 wdata=0f20", mem_we, mem_addr, mem_wdata);
      end
`else
      if (mem_we !== 1'b0) begin n_bad++; $display("FAIL bs_origin_ignored: got we=%b want 0", mem_we); end
`endif
   endtask

   task automatic test_opcode_arg;
      send(8'h01); send(8'h03); send(8'h0A);
      send(8'h4A);
      @(negedge clk);
      n_cmp++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'd310, 16'h0F4A}) begin
         n_bad++;
         $display("FAIL opcode_args: got we=%b addr=%0d wdata=%h want we=1 addr=310 wdata=0f4a", mem_we, mem_addr, mem_wdata);
      end
      send(8'h02); send(8'h1E);
      send(8'h4B);
      @(negedge clk);
      n_cmp++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'd311, 16'h1E4B}) begin
         n_bad++;
         $display("FAIL set_attr: got we=%b addr=%0d wdata=%h want we=1 addr=311 wdata=1e4b", mem_we, mem_addr, mem_wdata);
      end
   endtask

   task automatic test_clear;
      int nw;
      int bad;
      int ack_busy;
      int k;
      nw = 0; bad = 0; ack_busy = 0; k = 0;
      send(8'h03);
      @(posedge clk);
      #1;
      cmd_data  = 8'h41;
      cmd_avail = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (busy === 1'b1) begin
            if (mem_we !== 1'b1 || mem_addr !== 12'(nw) || mem_wdata !== 16'h1E20) bad++;
            if (cmd_ack === 1'b1) ack_busy++;
            nw++;
         end else if (nw > 0) begin
            break;
         end else if (mem_we === 1'b1) begin
            bad++;
         end
      end
      n_cmp++;
      if (nw !== 3700) begin n_bad++; $display("FAIL clear_len: got %0d busy cycles want 3700", nw); end
      n_cmp++;
      if (bad !== 0) begin n_bad++; $display("FAIL clear_seq: got %0d bad fill cycles want 0", bad); end
      n_cmp++;
      if (ack_busy !== 0) begin n_bad++; $display("FAIL clear_ack: got %0d acks while busy want 0", ack_busy); end
      n_cmp++;
      if (mem_we !== 1'b0) begin n_bad++; $display("FAIL clear_end_we: got we=%b want 0", mem_we); end
      while (cmd_ack !== 1'b1 && k < 10) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (cmd_ack !== 1'b1) begin n_bad++; $display("FAIL clear_resume_ack: got %b want 1", cmd_ack); end
      cmd_avail = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'd0, 16'h1E41}) begin
         n_bad++;
         $display("FAIL clear_home: got we=%b addr=%0d wdata=%h want we=1 addr=0 wdata=1e41", mem_we, mem_addr, mem_wdata);
      end
   endtask

   task automatic test_reset_abort;
      int nw;
      nw = 0;
      send(8'h03);
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (busy === 1'b1) nw++;
         if (nw == 100) break;
      end
      n_cmp++;
      if (nw !== 100) begin n_bad++; $display("FAIL abort_fill_start: got %0d writes want 100", nw); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if ({mem_we, busy} !== 2'b00) begin
         n_bad++;
         $display("FAIL abort_clear: got we=%b busy=%b want we=0 busy=0", mem_we, busy);
      end
      @(negedge clk);
      n_cmp++;
      if (mem_we !== 1'b0) begin n_bad++; $display("FAIL abort_no_resume: got we=%b want 0", mem_we); end
      send(8'h01); send(8'h05);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      send(8'h41);
      @(negedge clk);
      n_cmp++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'd0, 16'h0F41}) begin
         n_bad++;
         $display("FAIL abort_args: got we=%b addr=%0d wdata=%h want we=1 addr=0 wdata=0f41", mem_we, mem_addr, mem_wdata);
      end
   endtask

   task automatic test_back_to_back;
      int idx;
      int wc;
      int bad;
      int viol;
      logic prev;
      logic [7:0] ch;
      idx = 0; wc = 0; bad = 0; viol = 0; prev = 1'b0;
      cmd_data  = 8'h50;
      cmd_avail = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (cmd_ack === 1'b1 && prev) viol++;
         prev = cmd_ack;
         if (mem_we === 1'b1) begin
            ch = 8'h50 + 8'(wc);
            if (mem_addr !== 12'(1 + wc) || mem_wdata !== {8'h0F, ch}) bad++;
            wc++;
         end
         if (cmd_ack === 1'b1) begin
            @(posedge clk);
            #1;
            idx++;
            if (idx < 4) cmd_data = 8'h50 + 8'(idx);
            else cmd_avail = 1'b0;
         end
         if (idx >= 4 && wc >= 4) break;
      end
      n_cmp++;
      if (wc !== 4) begin n_bad++; $display("FAIL b2b_count: got %0d writes want 4", wc); end
      n_cmp++;
      if (bad !== 0) begin n_bad++; $display("FAIL b2b_data: got %0d bad writes want 0", bad); end
      n_cmp++;
      if (viol !== 0) begin n_bad++; $display("FAIL b2b_ack_spacing: got %0d consecutive acks want 0", viol); end
   endtask

   initial begin
      test_reset;
      test_char;
      test_setpos_wrap;
      test_out_of_range;
      test_newline;
      test_backspace;
      test_opcode_arg;
      test_clear;
      test_reset_abort;
      test_back_to_back;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
